// File: rtl/reg_file_4x32_wq.sv
// 4-entry register file behind a posted-write FIFO; an accepted write is readable (forwarded) next cycle and commits one edge after that when hold=0.
// wr_ready = !full, depends only on queue occupancy; hold only stalls commits. Optional RF_ZERO_REG_EN hardwires register 0 to zero.
module reg_file_4x32_wq #(
  parameter int               WIDTH     = 32,
  parameter int               QDEPTH    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [1:0]               wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     hold,
  input  logic [1:0]               rd_addr_a,
  output logic [WIDTH-1:0]         rd_data_a,
  input  logic [1:0]               rd_addr_b,
  output logic [WIDTH-1:0]         rd_data_b,
  output logic [WIDTH-1:0]         q0,
  output logic [WIDTH-1:0]         q1,
  output logic [WIDTH-1:0]         q2,
  output logic [WIDTH-1:0]         q3,
  output logic [3:0]               pend,
  output logic [$clog2(QDEPTH):0]  q_count
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
`ifdef RF_ZERO_REG_EN
  localparam bit ZeroReg = 1'b1;
`else
  localparam bit ZeroReg = 1'b0;
`endif

  logic [WIDTH-1:0] regs  [4];
  logic [1:0]       qAddr [QDEPTH];
  logic [WIDTH-1:0] qData [QDEPTH];
  logic [PW-1:0]    headPtr;
  logic [PW-1:0]    tailPtr;
  logic [CW-1:0]    count;
  logic             doPush;
  logic             doPop;
  logic             commitEn;
  logic [WIDTH-1:0] rdA;
  logic [WIDTH-1:0] rdB;
  logic [3:0]       pendV;

  assign wr_ready = (count != CW'(QDEPTH));
  assign doPush   = wr_valid & wr_ready;
  assign doPop    = !hold && (count != '0);
  // Writes to a hardwired-zero register still pop; they just never land.
  assign commitEn = doPop && !(ZeroReg && (qAddr[headPtr] == 2'd0));

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) regs[i] <= RESET_VAL;
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (doPush) begin
        qAddr[tailPtr] <= wr_addr;
        qData[tailPtr] <= wr_data;
        tailPtr        <= tailPtr + PW'(1);
      end
      if (commitEn) regs[qAddr[headPtr]] <= qData[headPtr];
      if (doPop)    headPtr <= headPtr + PW'(1);
      if (doPush && !doPop)      count <= count + CW'(1);
      else if (!doPush && doPop) count <= count - CW'(1);
    end
  end

  // Walk entries oldest to youngest so the youngest match overrides.
  always_comb begin
    rdA   = regs[rd_addr_a];
    rdB   = regs[rd_addr_b];
    pendV = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (CW'(i) < count) begin
        if (!(ZeroReg && (qAddr[headPtr + PW'(i)] == 2'd0))) begin
          if (qAddr[headPtr + PW'(i)] == rd_addr_a) rdA = qData[headPtr + PW'(i)];
          if (qAddr[headPtr + PW'(i)] == rd_addr_b) rdB = qData[headPtr + PW'(i)];
          pendV[qAddr[headPtr + PW'(i)]] = 1'b1;
        end
      end
    end
    if (ZeroReg && (rd_addr_a == 2'd0)) rdA = '0;
    if (ZeroReg && (rd_addr_b == 2'd0)) rdB = '0;
  end

  assign rd_data_a = rdA;
  assign rd_data_b = rdB;
  assign pend      = pendV;
  assign q_count   = count;
  assign q0        = ZeroReg ? '0 : regs[0];
  assign q1        = regs[1];
  assign q2        = regs[2];
  assign q3        = regs[3];

endmodule
